cfg_bus_writer: RTL and testbench
=================================

# cfg_bus_writer

Master for the 32-bit configuration GPIO bus: accepts a write request (target address plus a 1..MAX_BYTES-byte value) over a valid/ready handshake and serialises it most-significant byte first onto the bus as strobed byte writes. Sits directly upstream of every configuration-register slave on the bus, driving the shared gpio word those slaves decode. Each strobe pulse shifts exactly one byte into the addressed slave.

## Interface
- MAX_BYTES, 4, largest request length in bytes (1..16)
- SETUP_CYC, 1, cycles addr/data are stable with w_clk low before the strobe (>=1)
- STROBE_CYC, 2, cycles w_clk is held high (>=1)
- GAP_CYC, 2, cycles w_clk is low after the strobe, addr/data held (>=1)
- IDLE_ADDR, 16'hFFFF, address driven when no transfer is active; no slave may use it
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_addr  in  16  target slave address
- req_data  in  8*MAX_BYTES  value; request bytes are the low req_len bytes, MSB of those sent first
- req_len  in  5  byte count
- done  out  1  one-cycle pulse after the last byte's GAP phase
- gpio_out  out  32  [15:0] addr, [23:16] data, [24] w_clk, [31:25] zero

## Operation
- States: IDLE, SETUP, STROBE, GAP.
- IDLE: req_ready=1; gpio_out addr=IDLE_ADDR, data=0, w_clk=0. On req_valid&&req_ready latch addr, data, len; byte index = len-1; go SETUP.
- SETUP: drive latched addr and byte[index]; w_clk=0 for SETUP_CYC cycles; go STROBE.
- STROBE: same addr/data, w_clk=1 for STROBE_CYC cycles; go GAP.
- GAP: same addr/data, w_clk=0 for GAP_CYC cycles; if index==0 pulse done and go IDLE, else decrement index and go SETUP.
- req_ready=0 in all non-IDLE states; req_* ignored while busy.
- Phase counter width clog2(max(SETUP_CYC,STROBE_CYC,GAP_CYC)+1); index width clog2(MAX_BYTES).
- Reset (any time, including mid-transfer): state IDLE, req_ready=1 after deassertion, done=0, gpio_out = {7'b0, 1'b0, 8'h00, IDLE_ADDR}; in-flight request discarded, no partial strobe completed.

## Timing
- Request accepted at edge N: gpio_out shows new addr/byte from cycle N+1; w_clk rises at N+1+SETUP_CYC.
- Per byte: SETUP_CYC+STROBE_CYC+GAP_CYC cycles; a len-L request occupies L times that, done pulses in the cycle after the final GAP cycle (IDLE entered that cycle, req_ready=1 concurrently).
- Back-to-back: a request presented with done asserted is accepted that same cycle.
- Outputs registered; no combinational path from req_* to gpio_out.
- Addr/data never change while w_clk=1 or in the cycle w_clk falls.

## Configuration
- CFG_BUS_WRITER_LEN_CHECK_EN defined: a request with req_len==0 or req_len>MAX_BYTES is accepted (handshake completes) but nothing is driven; extra output err (1 bit, reset 0) pulses one cycle after acceptance, done does not pulse.
- Undefined: no err port; req_len==0 is treated as 1, req_len>MAX_BYTES clamped to MAX_BYTES.

## Structure
- Package cfg_bus_pkg: bit-position constants (ADDR_LSB=0, DATA_LSB=16, WCLK_BIT=24), state enum, IDLE_ADDR default.
- One sub-module: cfg_phase_timer (loadable down-counter with zero flag) shared by the three timed phases.

## Test plan
- Defaults, req addr=16'h0003, len=4, data=32'hA1B2C3D4 -> four strobes carrying A1,B2,C3,D4 at addr 0003, each w_clk high 2 cycles, done 20 cycles after acceptance.
- len=1, data low byte 8'h5A -> single strobe of 5A, done after 5 cycles, addr returns to FFFF.
- req_valid held high across two requests -> second accepted in the done cycle, no extra idle cycle.
- Reset asserted during STROBE of byte 2 of 4 -> gpio_out immediately 32'h0000FFFF, done never pulses, req_ready=1 after release.
- req_valid during busy with different addr -> ignored; in-flight bytes unchanged.
- With CFG_BUS_WRITER_LEN_CHECK_EN, len=0 -> err pulse, w_clk stays 0; without it, len=7 -> 4 bytes sent.

Source files
------------

// File: rtl/cfg_bus_pkg.sv
// Shared definitions for the configuration GPIO bus writer: gpio word layout,
// FSM state encoding, the idle address default and small helpers.
package cfg_bus_pkg;

    localparam int ADDR_LSB = 0;
    localparam int DATA_LSB = 16;
    localparam int WCLK_BIT = 24;

    localparam logic [15:0] IDLE_ADDR_DEF = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        GAP    = 2'd3
    } cfg_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bits [31:25] are always zero on this bus.
    function automatic logic [31:0] gpio_word(input logic [15:0] addr,
                                              input logic [7:0]  data,
                                              input logic        wclk);
        logic [31:0] w;
        w = '0;
        w[ADDR_LSB +: 16] = addr;
        w[DATA_LSB +: 8]  = data;
        w[WCLK_BIT]       = wclk;
        return w;
    endfunction

endpackage

// File: rtl/cfg_bus_writer_if.sv
// Request handshake and gpio bus bundle for cfg_bus_writer. The err signal
// exists only when CFG_BUS_WRITER_LEN_CHECK_EN is defined.
interface cfg_bus_writer_if #(
    parameter int MAX_BYTES = 4
);
    // req_valid/req_ready: a request transfers on every clock edge where both
    // are high; the requester holds req_* stable while req_valid is high and
    // req_ready is low. req_* are ignored while the writer is busy.
    logic                   req_valid;
    logic                   req_ready;
    logic [15:0]            req_addr;
    logic [8*MAX_BYTES-1:0] req_data;
    logic [4:0]             req_len;
    logic                   done;
    logic [31:0]            gpio_out;
`ifdef CFG_BUS_WRITER_LEN_CHECK_EN
    logic                   err;
`endif

    // master: the bus writer itself; slave: the upstream requester / observer.
    modport master (
        input  req_valid, req_addr, req_data, req_len,
        output req_ready, done, gpio_out
`ifdef CFG_BUS_WRITER_LEN_CHECK_EN
        , output err
`endif
    );

    modport slave (
        output req_valid, req_addr, req_data, req_len,
        input  req_ready, done, gpio_out
`ifdef CFG_BUS_WRITER_LEN_CHECK_EN
        , input err
`endif
    );

endinterface

// File: rtl/cfg_phase_timer.sv
// Loadable down-counter with a zero flag; times the SETUP, STROBE and GAP
// phases of the bus writer.
module cfg_phase_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/cfg_bus_writer.sv
// Serialises write requests MSB-first onto the 32-bit configuration gpio bus
// as strobed byte writes. Optional length checking: CFG_BUS_WRITER_LEN_CHECK_EN.
module cfg_bus_writer
    import cfg_bus_pkg::*;
#(
    parameter int          MAX_BYTES  = 4,
    parameter int          SETUP_CYC  = 1,
    parameter int          STROBE_CYC = 2,
    parameter int          GAP_CYC    = 2,
    parameter logic [15:0] IDLE_ADDR  = IDLE_ADDR_DEF
) (
    input  logic              clk,
    input  logic              rst,
    cfg_bus_writer_if.master  bus,
    output cfg_state_e        state_dbg
);

    localparam int CNT_W  = $clog2(max3(SETUP_CYC, STROBE_CYC, GAP_CYC) + 1);
    localparam int IDX_W  = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int DATA_W = 8 * MAX_BYTES;

    // Timer is loaded with N-1 so the zero flag marks the last cycle of a phase.
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(GAP_CYC - 1);

    cfg_state_e        state_q, state_d;
    logic [15:0]       addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [31:0]       gpio_q, gpio_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
`ifdef CFG_BUS_WRITER_LEN_CHECK_EN
    logic              err_q, err_d;
`endif

    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_val;
    logic              tmr_zero;

    logic [4:0]        eff_len;
    logic [4:0]        len_m1;
    logic              len_ok;
    logic [DATA_W-1:0] data_shift;
    logic [7:0]        byte_sel;

    cfg_phase_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        idx_d    = idx_q;
        done_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
`ifdef CFG_BUS_WRITER_LEN_CHECK_EN
        err_d    = 1'b0;
        eff_len  = bus.req_len;
        len_ok   = (bus.req_len != 5'd0) && (bus.req_len <= 5'(MAX_BYTES));
`else
        len_ok   = 1'b1;
        if (bus.req_len == 5'd0) begin
            eff_len = 5'd1;
        end else if (bus.req_len > 5'(MAX_BYTES)) begin
            eff_len = 5'(MAX_BYTES);
        end else begin
            eff_len = bus.req_len;
        end
`endif
        len_m1 = eff_len - 5'd1;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && ready_q) begin
                    addr_d = bus.req_addr;
                    data_d = bus.req_data;
                    if (len_ok) begin
                        idx_d    = len_m1[IDX_W-1:0];
                        state_d  = SETUP;
                        tmr_load = 1'b1;
                        tmr_val  = SETUP_LD;
                    end
`ifdef CFG_BUS_WRITER_LEN_CHECK_EN
                    else begin
                        err_d = 1'b1;
                    end
`endif
                end
            end
            SETUP: begin
                if (tmr_zero) begin
                    state_d  = STROBE;
                    tmr_load = 1'b1;
                    tmr_val  = STROBE_LD;
                end
            end
            STROBE: begin
                if (tmr_zero) begin
                    state_d  = GAP;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LD;
                end
            end
            GAP: begin
                if (tmr_zero) begin
                    if (idx_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d    = idx_q - IDX_W'(1);
                        state_d  = SETUP;
                        tmr_load = 1'b1;
                        tmr_val  = SETUP_LD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);

        // Outputs are computed from next-state values so the registered
        // gpio word lines up with the state it belongs to.
        data_shift = data_d >> {idx_d, 3'b000};
        byte_sel   = data_shift[7:0];
        if (state_d == IDLE) begin
            gpio_d = gpio_word(IDLE_ADDR, 8'h00, 1'b0);
        end else begin
            gpio_d = gpio_word(addr_d, byte_sel, state_d == STROBE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            gpio_q  <= gpio_word(IDLE_ADDR, 8'h00, 1'b0);
            done_q  <= 1'b0;
            ready_q <= 1'b1;
`ifdef CFG_BUS_WRITER_LEN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            gpio_q  <= gpio_d;
            done_q  <= done_d;
            ready_q <= ready_d;
`ifdef CFG_BUS_WRITER_LEN_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.done      = done_q;
    assign bus.gpio_out  = gpio_q;
`ifdef CFG_BUS_WRITER_LEN_CHECK_EN
    assign bus.err       = err_q;
`endif
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_cfg_bus_writer.sv
// Self-checking bench for cfg_bus_writer: randomized and directed requests,
// expected strobes/done pulses queued by a reference model, checked by a monitor.
module tb_cfg_bus_writer;
    import cfg_bus_pkg::*;

    localparam int MAX_BYTES  = 4;
    localparam int SETUP_CYC  = 1;
    localparam int STROBE_CYC = 2;
    localparam int GAP_CYC    = 2;
    localparam int PER        = SETUP_CYC + STROBE_CYC + GAP_CYC;
    localparam int DW         = 8 * MAX_BYTES;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    cfg_state_e state_dbg;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;

    cfg_bus_writer_if #(.MAX_BYTES(MAX_BYTES)) bus ();

    cfg_bus_writer #(
        .MAX_BYTES  (MAX_BYTES),
        .SETUP_CYC  (SETUP_CYC),
        .STROBE_CYC (STROBE_CYC),
        .GAP_CYC    (GAP_CYC),
        .IDLE_ADDR  (16'hFFFF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.master),
        .state_dbg (state_dbg)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard queues: strobe entries are {rise_cycle, addr, byte}
    logic [55:0] exp_q[$];
    logic [31:0] done_exp_q[$];
    logic [31:0] err_exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: the accepting edge is the one after negedge cycle k.
    task automatic model_push(input logic [15:0] addr, input logic [DW-1:0] data,
                              input logic [4:0] len, input int k);
        int a;
        int l;
        logic [DW-1:0] sh;
        a = k + 1;
        l = int'(len);
`ifdef CFG_BUS_WRITER_LEN_CHECK_EN
        if (l == 0 || l > MAX_BYTES) begin
            err_exp_q.push_back(32'(a));
            return;
        end
`else
        if (l == 0) l = 1;
        if (l > MAX_BYTES) l = MAX_BYTES;
`endif
        for (int i = 0; i < l; i++) begin
            sh = data >> (8 * (l - 1 - i));
            exp_q.push_back({32'(a + i * PER + SETUP_CYC), addr, sh[7:0]});
        end
        done_exp_q.push_back(32'(a + PER * l));
    endtask

    // driver tasks: always called just after a falling edge
    task automatic send(input logic [15:0] addr, input logic [DW-1:0] data,
                        input logic [4:0] len, output int k_acc);
        int w;
        w = 0;
        k_acc = -1;
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_data  = data;
        bus.req_len   = len;
        while (bus.req_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("accept_timeout", 64'(w < 200), 64'd1);
        if (w < 200) begin
            k_acc = cyc;
            model_push(addr, data, len, cyc);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic poke_busy(input int n);
        bus.req_valid = 1'b1;
        bus.req_addr  = 16'h0BAD;
        bus.req_data  = DW'(32'hEEEEEEEE);
        bus.req_len   = 5'd1;
        for (int i = 0; i < n; i++) begin
            check("busy_ready", 64'(bus.req_ready), 64'd0);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || done_exp_q.size() != 0 || err_exp_q.size() != 0) && w < 500) begin
            @(negedge clk);
            w++;
        end
        check("drain_timeout", 64'(w < 500), 64'd1);
        @(negedge clk);
    endtask

    // monitor
    logic        prev_w = 1'b0;
    int          hi_cnt = 0;
    logic [23:0] held = '0;

    always @(negedge clk) begin
        logic        w;
        logic [55:0] e;
        logic [31:0] d;
        if (!rst) begin
            prev_w = 1'b0;
            hi_cnt = 0;
        end else begin
            w = bus.gpio_out[WCLK_BIT];
            if (w && !prev_w) begin
                if (exp_q.size() == 0) begin
                    check("extra_strobe", 64'(bus.gpio_out), 64'(32'h0000FFFF));
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_cycle", 64'(cyc), 64'(e[55:24]));
                    check("strobe_addr", 64'(bus.gpio_out[15:0]), 64'(e[23:8]));
                    check("strobe_data", 64'(bus.gpio_out[23:16]), 64'(e[7:0]));
                end
                check("upper_zero", 64'(bus.gpio_out[31:25]), 64'd0);
                held   = bus.gpio_out[23:0];
                hi_cnt = 1;
            end else if (w) begin
                hi_cnt++;
                check("hold_high", 64'(bus.gpio_out[23:0]), 64'(held));
            end else if (prev_w) begin
                check("strobe_width", 64'(hi_cnt), 64'(STROBE_CYC));
                check("hold_fall", 64'(bus.gpio_out[23:0]), 64'(held));
            end
            if (bus.done) begin
                if (done_exp_q.size() == 0) begin
                    check("extra_done", 64'(bus.done), 64'd0);
                end else begin
                    d = done_exp_q.pop_front();
                    check("done_cycle", 64'(cyc), 64'(d));
                end
                check("done_idle_gpio", 64'(bus.gpio_out), 64'(32'h0000FFFF));
            end
`ifdef CFG_BUS_WRITER_LEN_CHECK_EN
            if (bus.err) begin
                if (err_exp_q.size() == 0) begin
                    check("extra_err", 64'(bus.err), 64'd0);
                end else begin
                    d = err_exp_q.pop_front();
                    check("err_cycle", 64'(cyc), 64'(d));
                end
                check("err_wclk", 64'(w), 64'd0);
            end
`endif
            prev_w = w;
        end
    end

    // stimulus
    initial begin
        int k1;
        int k2;
        int w;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.req_len   = '0;

        // reset
        repeat (3) @(negedge clk);
        check("rst_gpio", 64'(bus.gpio_out), 64'(32'h0000FFFF));
        check("rst_done", 64'(bus.done), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_ready", 64'(bus.req_ready), 64'd1);
        check("rst_state", 64'(state_dbg), 64'(IDLE));

        // four-byte request
        send(16'h0003, DW'(32'hA1B2C3D4), 5'd4, k1);
        idle(0);
        drain();

        // single byte
        send(16'h0012, DW'(32'h1234565A), 5'd1, k1);
        idle(0);
        drain();

        // back-to-back with req_valid held high
        send(16'h0100, DW'($urandom), 5'd3, k1);
        send(16'h0101, DW'($urandom), 5'd2, k2);
        check("b2b_accept", 64'(k2), 64'(k1 + 1 + 3 * PER));
        idle(0);
        drain();

        // request presented while busy is ignored
        send(16'h0040, DW'(32'h0F1E2D3C), 5'd4, k1);
        poke_busy(10);
        drain();

        // reset during STROBE of byte 2 of 4
        send(16'h0077, DW'(32'h11223344), 5'd4, k1);
        idle(0);
        w = 0;
        while (exp_q.size() > 2 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("reach_byte2", 64'(exp_q.size()), 64'd2);
        check("byte2_wclk", 64'(bus.gpio_out[WCLK_BIT]), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("midrst_gpio", 64'(bus.gpio_out), 64'(32'h0000FFFF));
        check("midrst_done", 64'(bus.done), 64'd0);
        exp_q.delete();
        done_exp_q.delete();
        err_exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready", 64'(bus.req_ready), 64'd1);
        repeat (30) @(negedge clk);

        // out-of-range lengths
        send(16'h0005, DW'(32'hCAFEF00D), 5'd7, k1);
        idle(0);
        drain();
        send(16'h0006, DW'(32'h89ABCDEF), 5'd0, k1);
        idle(0);
        drain();

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            send(16'($urandom_range(0, 16'hFFFE)), DW'($urandom), 5'($urandom_range(0, 7)), k1);
            w = int'($urandom_range(0, 2));
            if (w > 0) idle(w);
        end
        idle(0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
